// File: rtl/controle_desvio_fsm_if.sv
// controle_desvio_fsm_if: branch-control signals between the pipeline and the branch FSM
interface controle_desvio_fsm_if;
  logic [1:0] sinalBranch;
  logic       validoBranch;
  logic       zeroULA;
  logic       stallExterno;
  logic       selPC;
  logic       flushIFID;
  logic       flushIDEX;
  logic       stallPC;
  logic       ocupado;
  logic [7:0] contTomados;
  logic [7:0] contNaoTomados;
  modport master (
    output sinalBranch, validoBranch, zeroULA, stallExterno,
    input  selPC, flushIFID, flushIDEX, stallPC, ocupado, contTomados, contNaoTomados
  );
  modport slave (
    input  sinalBranch, validoBranch, zeroULA, stallExterno,
    output selPC, flushIFID, flushIDEX, stallPC, ocupado, contTomados, contNaoTomados
  );
endinterface

// File: rtl/controle_desvio_fsm.sv
// controle_desvio_fsm: resolves beq/bne in EX, redirects the PC and flushes the pipeline
module controle_desvio_fsm (
  input logic                  clk,
  input logic                  reset,
  controle_desvio_fsm_if.slave bus
);
  localparam logic [1:0] OCIOSO      = 2'b00;
  localparam logic [1:0] AVALIA      = 2'b01;
  localparam logic [1:0] REDIRECIONA = 2'b10;
  localparam logic [1:0] DRENA       = 2'b11;
  logic [1:0] state_q, state_d;
  logic [1:0] sinal_q, sinal_d;
  logic       zero_q, zero_d;
  logic [7:0] tom_q, tom_d, nao_q, nao_d;
  logic       aceita, tomado;
  always_comb begin
    aceita  = bus.validoBranch && (bus.sinalBranch == 2'b10 || bus.sinalBranch == 2'b01);
    tomado  = (sinal_q == 2'b10 && zero_q) || (sinal_q == 2'b01 && !zero_q);
    state_d = state_q;
    sinal_d = sinal_q;
    zero_d  = zero_q;
    tom_d   = tom_q;
    nao_d   = nao_q;
    if (!bus.stallExterno) begin
      state_d = state_q == OCIOSO      ? (aceita ? AVALIA : OCIOSO) :
                state_q == AVALIA      ? (tomado ? REDIRECIONA : OCIOSO) :
                state_q == REDIRECIONA ? DRENA : OCIOSO;
      if (state_q == OCIOSO && aceita) begin
        sinal_d = bus.sinalBranch;
        zero_d  = bus.zeroULA;
      end
      // counters saturate at 8'hFF instead of wrapping
      if (state_q == AVALIA) begin
        tom_d = tom_q + 8'(tomado && tom_q != 8'hFF);
        nao_d = nao_q + 8'(!tomado && nao_q != 8'hFF);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OCIOSO;
      sinal_q <= 2'b00;
      zero_q  <= 1'b0;
      tom_q   <= 8'h00;
      nao_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      sinal_q <= sinal_d;
      zero_q  <= zero_d;
      tom_q   <= tom_d;
      nao_q   <= nao_d;
    end
  end
  assign bus.selPC          = state_q == REDIRECIONA;
  assign bus.flushIFID      = state_q[1];
  assign bus.flushIDEX      = state_q == REDIRECIONA;
  assign bus.stallPC        = state_q == AVALIA;
  assign bus.ocupado        = state_q != OCIOSO;
  assign bus.contTomados    = tom_q;
  assign bus.contNaoTomados = nao_q;
endmodule

// File: tb/tb_controle_desvio_fsm.sv
// tb_controle_desvio_fsm: directed and random checks against a queue-based branch model
module tb_controle_desvio_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  controle_desvio_fsm_if bus();
  controle_desvio_fsm dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [4:0] o;
    int         inc;
  } ent_t;
  ent_t q[$];
  int m_t, m_n;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drv(logic r, logic [1:0] s, logic v, logic z, logic st);
    reset = r;
    bus.sinalBranch = s;
    bus.validoBranch = v;
    bus.zeroULA = z;
    bus.stallExterno = st;
  endtask
  function automatic logic [4:0] outs();
    return {bus.selPC, bus.flushIFID, bus.flushIDEX, bus.stallPC, bus.ocupado};
  endfunction
  task automatic cyc();
    ent_t e;
    bit tk;
    @(posedge clk);
    // outputs per pending phase: {selPC, flushIFID, flushIDEX, stallPC, ocupado}
    if (reset) begin
      q.delete();
      m_t = 0;
      m_n = 0;
    end else if (!bus.stallExterno) begin
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.inc == 1 && m_t < 255) m_t++;
        if (e.inc == 2 && m_n < 255) m_n++;
      end else if (bus.validoBranch && (bus.sinalBranch == 2'b10 || bus.sinalBranch == 2'b01)) begin
        tk = bus.sinalBranch == 2'b10 ? bus.zeroULA : !bus.zeroULA;
        q.push_back('{5'b00011, tk ? 1 : 2});
        if (tk) begin
          q.push_back('{5'b11101, 0});
          q.push_back('{5'b01001, 0});
        end
      end
    end
    #1;
    chk("outs", 32'(outs()), q.size() != 0 ? 32'(q[0].o) : 32'd0);
    chk("tomados", 32'(bus.contTomados), 32'(m_t));
    chk("nao_tomados", 32'(bus.contNaoTomados), 32'(m_n));
  endtask
  initial begin
    int sel_n, base;
    bit found;
    m_t = 0;
    m_n = 0;
    drv(1, 2'b00, 0, 0, 0);
    repeat (2) cyc();
    chk("reset_outs", 32'(outs()), 0);
    drv(0, 2'b00, 0, 0, 0);
    cyc();
    chk("post_reset_outs", 32'(outs()), 0);
    drv(0, 2'b10, 1, 1, 0);
    cyc();
    drv(0, 2'b00, 0, 0, 0);
    chk("beq_t1", 32'(outs()), 32'b00011);
    cyc();
    chk("beq_t2", 32'(outs()), 32'b11101);
    cyc();
    chk("beq_t3", 32'(outs()), 32'b01001);
    cyc();
    chk("beq_t4", 32'(outs()), 0);
    chk("beq_cnt", 32'(bus.contTomados), 1);
    drv(0, 2'b01, 1, 1, 0);
    cyc();
    drv(0, 2'b00, 0, 0, 0);
    chk("bne_t1", 32'(outs()), 32'b00011);
    sel_n = 0;
    repeat (3) begin
      cyc();
      sel_n += int'(bus.selPC);
    end
    chk("bne_sel", 32'(sel_n), 0);
    chk("bne_cnt", 32'(bus.contNaoTomados), 1);
    drv(0, 2'b11, 1, 0, 0);
    repeat (3) cyc();
    drv(0, 2'b10, 0, 1, 0);
    repeat (3) cyc();
    chk("nobranch_busy", 32'(bus.ocupado), 0);
    chk("nobranch_cnt", 32'({bus.contTomados, bus.contNaoTomados}), 32'h0101);
    base = int'(bus.contTomados);
    drv(0, 2'b10, 1, 1, 0);
    cyc();
    sel_n = 0;
    for (int i = 0; i < 8; i++) begin
      drv(0, 2'b00, 0, 0, i >= 1 && i <= 3);
      cyc();
      sel_n += int'(bus.selPC);
    end
    chk("stall_sel", 32'(sel_n), 4);
    chk("stall_cnt", 32'(int'(bus.contTomados) - base), 1);
    drv(1, 2'b00, 0, 0, 0);
    cyc();
    drv(0, 2'b10, 1, 1, 0);
    repeat (1210) cyc();
    chk("sat_tom", 32'(bus.contTomados), 32'hFF);
    chk("sat_nao", 32'(bus.contNaoTomados), 0);
    drv(1, 2'b00, 0, 0, 0);
    cyc();
    drv(0, 2'b10, 1, 1, 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      found = m_t == 5 && q.size() == 1 && q[0].o == 5'b01001;
    end
    chk("drena_reached", 32'(found), 1);
    drv(1, 2'b10, 1, 1, 1);
    cyc();
    chk("drena_reset_outs", 32'(outs()), 0);
    chk("drena_reset_cnt", 32'({bus.contTomados, bus.contNaoTomados}), 0);
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 99) == 0, 2'($urandom), $urandom_range(0, 3) != 0,
          1'($urandom), $urandom_range(0, 3) == 0);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/controle_desvio_fsm.md
CONTROLE_DESVIO_FSM -- requirements
Module: controle_desvio_fsm

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state updates SHALL occur on the rising edge of clk.
REQ-002 The clock port SHALL be: clk  input  1  system clock.
REQ-003 The reset port SHALL be: reset  input  1  synchronous active-high reset.
REQ-004 The branch-type port SHALL be: sinalBranch  input  2  branch type from decode; 10=beq, 01=bne, 00/11=no branch.
REQ-005 The branch-valid port SHALL be: validoBranch  input  1  branch instruction present in EX this cycle.
REQ-006 The ALU-zero port SHALL be: zeroULA  input  1  ALU zero flag for the EX instruction.
REQ-007 The external-stall port SHALL be: stallExterno  input  1  memory/pipeline freeze; 1 = hold the FSM.
REQ-008 The PC-select port SHALL be: selPC  output  1  1 = PC loads the branch target.
REQ-009 The IF/ID flush port SHALL be: flushIFID  output  1  flush the IF/ID register.
REQ-010 The ID/EX flush port SHALL be: flushIDEX  output  1  flush the ID/EX register.
REQ-011 The PC-stall port SHALL be: stallPC  output  1  hold the PC.
REQ-012 The busy port SHALL be: ocupado  output  1  FSM is not idle.
REQ-013 The taken-count port SHALL be: contTomados  output  8  count of taken branches.
REQ-014 The not-taken-count port SHALL be: contNaoTomados  output  8  count of not-taken branches.

Function
REQ-015 The FSM SHALL have four Moore states: OCIOSO=00, AVALIA=01, REDIRECIONA=10, DRENA=11.
REQ-016 All outputs other than the counters SHALL be decoded from the state only, as follows:
- OCIOSO: all 0.
- AVALIA: stallPC=1, ocupado=1.
- REDIRECIONA: selPC=1, flushIFID=1, flushIDEX=1, ocupado=1.
- DRENA: flushIFID=1, ocupado=1.
REQ-017 OCIOSO->AVALIA SHALL occur when validoBranch=1, sinalBranch is 10 or 01, and stallExterno=0; on that edge sinalBranch and zeroULA SHALL be latched.
REQ-018 When sinalBranch is 00 or 11, or validoBranch=0, the FSM SHALL remain in OCIOSO and latch nothing.
REQ-019 In AVALIA, the taken decision SHALL be (latched sinal=10 AND latched zero=1) OR (latched sinal=01 AND latched zero=0).
REQ-020 In AVALIA, a taken decision SHALL move the FSM to REDIRECIONA and increment contTomados.
REQ-021 In AVALIA, a not-taken decision SHALL move the FSM to OCIOSO and increment contNaoTomados.
REQ-022 REDIRECIONA SHALL move to DRENA, and DRENA SHALL move to OCIOSO, each unconditionally when stallExterno=0.
REQ-023 Latency SHALL be: acceptance edge T, AVALIA during cycle T+1, selPC=1 during cycle T+2 for a taken branch; a not-taken branch SHALL return ocupado to 0 in cycle T+2.
REQ-024 While stallExterno=1, the FSM SHALL hold its state, its outputs and its latches, and neither counter SHALL change.
REQ-025 validoBranch SHALL be ignored in every state except OCIOSO; back-to-back requests SHALL be accepted only from OCIOSO.
REQ-026 Each counter SHALL saturate at 8'hFF and SHALL NOT wrap to 0.
REQ-027 At most one counter SHALL increment per cycle.

Reset
REQ-028 When reset=1 at a rising edge, the next state SHALL be: state=OCIOSO, latches=0, contTomados=0, contNaoTomados=0, and all 1-bit outputs 0.
REQ-029 Reset SHALL take priority over stallExterno and over every transition, including reset asserted in REDIRECIONA or DRENA, which aborts the redirect.
REQ-030 No 1-bit output SHALL be asserted in the first cycle after reset deasserts.

Verification
REQ-031 The bench SHALL cover: beq with sinal=10, zero=1, valid=1 at edge T -> stallPC=1 in T+1; selPC=flushIFID=flushIDEX=1 in T+2; flushIFID only in T+3; idle in T+4; contTomados=1.
REQ-032 The bench SHALL cover: bne with sinal=01, zero=1 -> AVALIA for one cycle, then idle with selPC never 1; contNaoTomados=1.
REQ-033 The bench SHALL cover: sinal=11 with valid=1, and sinal=10 with valid=0 -> ocupado stays 0 and both counters are unchanged.
REQ-034 The bench SHALL cover: stallExterno=1 for 3 cycles while in REDIRECIONA -> selPC held at 1 for 4 cycles total, and a single increment of contTomados.
REQ-035 The bench SHALL cover: 300 taken beq branches -> contTomados=8'hFF and contNaoTomados=0.
REQ-036 The bench SHALL cover: reset=1 during DRENA with contTomados=5 -> next cycle state=OCIOSO, all outputs 0, both counters 0.
